// File: rtl/iterative_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// Handles unsigned or two's-complement operands. Divide-by-zero and the
// signed most-negative / -1 case are resolved without extra cycles.
module iterative_divider #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             dbz_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    ONE_C  = CW'(1);
  localparam logic [CW-1:0]    ZERO_C = CW'(0);
  localparam logic [CW-1:0]    LOAD_C = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Two's-complement negation helper.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Magnitude of an operand; identity when operands are unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return (SIGNED && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dq_q, dq_d;           // dividend shifts out, quotient shifts in
  logic [WIDTH:0]   rem_q, rem_d;         // partial remainder, one guard bit
  logic [WIDTH-1:0] dsr_q, dsr_d;         // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;

  // One restoring step: shift in the next dividend bit and try the subtract.
  // A set guard bit would mean the shifted value already exceeds any divisor.
  always_comb begin
    trial_s = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
    diff_s  = trial_s - {1'b0, dsr_q};
    qbit_s  = rem_q[WIDTH] | (trial_s >= {1'b0, dsr_q});
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dbz_pend_d  = dbz_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          count_d = LOAD_C;
          rem_d   = {(WIDTH+1){1'b0}};
          dsr_d   = magnitude(divisor_in);
          q_neg_d = SIGNED && (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
          r_neg_d = SIGNED && dividend_in[WIDTH-1];
          if (divisor_in == ZERO_W) begin
            // Keep the raw dividend: it becomes the remainder unchanged.
            dbz_pend_d = 1'b1;
            dq_d       = dividend_in;
            state_d    = ST_FINISH;
          end else begin
            dbz_pend_d = 1'b0;
            dq_d       = magnitude(dividend_in);
            state_d    = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        count_d = count_q - ONE_C;
        dq_d    = {dq_q[WIDTH-2:0], qbit_s};
        rem_d   = qbit_s ? diff_s : trial_s;
        if (count_q == ONE_C) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FINISH: begin
        // Most-negative / -1 needs no special case: the magnitude quotient
        // is 2^(WIDTH-1), which reads back as the most-negative value.
        if (dbz_pend_q) begin
          quotient_d  = ONES_W;
          remainder_d = dq_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = q_neg_q ? negate(dq_q) : dq_q;
          remainder_d = r_neg_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        count_d = ZERO_C;
        state_d = ST_IDLE;
      end
      default: begin
        count_d = ZERO_C;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= ZERO_C;
      dq_q        <= ZERO_W;
      rem_q       <= {(WIDTH+1){1'b0}};
      dsr_q       <= ZERO_W;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_pend_q  <= 1'b0;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dbz_pend_q  <= dbz_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign quotient_out  = quotient_q;
  assign remainder_out = remainder_q;
  assign dbz_out       = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed testbench: one unsigned and one signed 8-bit divider share the
// stimulus; expected values are hand-computed constants.
module tb_iterative_divider;

  logic       clock;
  logic       reset;
  logic       start_in;
  logic [7:0] dividend_in;
  logic [7:0] divisor_in;

  logic       busy_u, done_u, dbz_u;
  logic [7:0] q_u, r_u;
  logic       busy_s, done_s, dbz_s;
  logic [7:0] q_s, r_s;

  int checks;
  int failures;

  iterative_divider #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
    .clock        (clock),
    .reset        (reset),
    .start_in     (start_in),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .busy_out     (busy_u),
    .done_out     (done_u),
    .quotient_out (q_u),
    .remainder_out(r_u),
    .dbz_out      (dbz_u)
  );

  iterative_divider #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
    .clock        (clock),
    .reset        (reset),
    .start_in     (start_in),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .busy_out     (busy_s),
    .done_out     (done_s),
    .quotient_out (q_s),
    .remainder_out(r_s),
    .dbz_out      (dbz_s)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one operation (the edge that samples start is E0) and wait for
  // done with a bounded budget. lat = edges from E0 to done, -1 on timeout.
  // busy_bad counts cycles where busy disagrees with the expected profile.
  // With poke set, a stray start with other operands is driven at E0+3.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit poke,
                       output int lat, output int busy_bad);
    dividend_in = a;
    divisor_in  = b;
    start_in    = 1'b1;
    tick();
    start_in    = 1'b0;
    dividend_in = 8'h5A;
    divisor_in  = 8'hA5;
    lat         = -1;
    busy_bad    = (busy_u !== 1'b1) ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      if (poke && i == 3) begin
        start_in    = 1'b1;
        dividend_in = 8'd10;
        divisor_in  = 8'd1;
      end
      tick();
      start_in = 1'b0;
      if (done_u === 1'b1) begin
        lat = i;
        if (busy_u !== 1'b0) busy_bad++;
        break;
      end else if (busy_u !== 1'b1) begin
        busy_bad++;
      end
    end
  endtask

  int lat;
  int bb;
  int ndone;

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    start_in    = 1'b0;
    dividend_in = 8'd0;
    divisor_in  = 8'd0;
    #3;
    chk("rst_busy", busy_u, 1'b0);
    chk("rst_done", done_u, 1'b0);
    chk("rst_q", q_u, 8'h00);
    chk("rst_r", r_u, 8'h00);
    chk("rst_dbz", dbz_u, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // 200/7 unsigned, with a stray start mid-operation that must be ignored
    do_op(8'd200, 8'd7, 1'b1, lat, bb);
    chk("u200_7_lat", lat, 9);
    chk("u200_7_busy", bb, 0);
    chk("u200_7_q", q_u, 8'd28);
    chk("u200_7_r", r_u, 8'd4);
    chk("u200_7_dbz", dbz_u, 1'b0);
    chk("s_done_same", done_s, 1'b1);
    tick();
    chk("done_one_cycle", done_u, 1'b0);
    tick();
    tick();
    chk("hold_q", q_u, 8'd28);
    chk("hold_r", r_u, 8'd4);

    // 55/0 divide by zero
    do_op(8'd55, 8'd0, 1'b0, lat, bb);
    chk("dbz_lat", lat, 1);
    chk("dbz_busy", bb, 0);
    chk("dbz_flag", dbz_u, 1'b1);
    chk("dbz_q", q_u, 8'hFF);
    chk("dbz_r", r_u, 8'd55);
    chk("dbz_s_flag", dbz_s, 1'b1);
    chk("dbz_s_q", q_s, 8'hFF);
    chk("dbz_s_r", r_s, 8'd55);

    // -7/2: signed -3 r -1; unsigned 249/2 = 124 r 1
    do_op(8'hF9, 8'h02, 1'b0, lat, bb);
    chk("m7_2_lat", lat, 9);
    chk("m7_2_s_q", q_s, 8'hFD);
    chk("m7_2_s_r", r_s, 8'hFF);
    chk("m7_2_s_dbz", dbz_s, 1'b0);
    chk("m7_2_u_q", q_u, 8'd124);
    chk("m7_2_u_r", r_u, 8'd1);

    // 7/-2: signed -3 r 1; unsigned 7/254 = 0 r 7
    do_op(8'h07, 8'hFE, 1'b0, lat, bb);
    chk("7_m2_s_q", q_s, 8'hFD);
    chk("7_m2_s_r", r_s, 8'h01);
    chk("7_m2_u_q", q_u, 8'd0);
    chk("7_m2_u_r", r_u, 8'd7);

    // -128/-1 overflow: signed 0x80 r 0; unsigned 128/255 = 0 r 128
    do_op(8'h80, 8'hFF, 1'b0, lat, bb);
    chk("ovf_lat", lat, 9);
    chk("ovf_s_q", q_s, 8'h80);
    chk("ovf_s_r", r_s, 8'h00);
    chk("ovf_s_dbz", dbz_s, 1'b0);
    chk("ovf_u_q", q_u, 8'd0);
    chk("ovf_u_r", r_u, 8'd128);

    // -128/7: signed -18 r -2
    do_op(8'h80, 8'h07, 1'b0, lat, bb);
    chk("m128_7_s_q", q_s, 8'hEE);
    chk("m128_7_s_r", r_s, 8'hFE);

    // boundary: 255/1 and 0/5 unsigned
    do_op(8'd255, 8'd1, 1'b0, lat, bb);
    chk("u255_1_q", q_u, 8'd255);
    chk("u255_1_r", r_u, 8'd0);
    do_op(8'd0, 8'd5, 1'b0, lat, bb);
    chk("u0_5_q", q_u, 8'd0);
    chk("u0_5_r", r_u, 8'd0);

    // Reset mid-operation: 100/3 at E0, stray 9/9 at E0+4, reset before E0+6
    dividend_in = 8'd100;
    divisor_in  = 8'd3;
    start_in    = 1'b1;
    tick();                       // E0
    start_in = 1'b0;
    tick();                       // E0+1
    tick();                       // E0+2
    tick();                       // E0+3
    dividend_in = 8'd9;
    divisor_in  = 8'd9;
    start_in    = 1'b1;
    tick();                       // E0+4
    start_in = 1'b0;
    tick();                       // E0+5
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy_u, 1'b0);
    chk("mid_rst_q", q_u, 8'h00);
    chk("mid_rst_r", r_u, 8'h00);
    chk("mid_rst_s_r", r_s, 8'h00);
    tick();                       // E0+6 under reset
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_u === 1'b1 || done_s === 1'b1) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    chk("idle_after_rst", busy_u, 1'b0);
    chk("outs_after_rst", {q_u, r_u, 7'd0, dbz_u}, 24'h000000);

    // Start on the first edge after reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_op(8'd9, 8'd9, 1'b0, lat, bb);
    chk("u9_9_lat", lat, 9);
    chk("u9_9_q", q_u, 8'd1);
    chk("u9_9_r", r_u, 8'd0);

    // Back-to-back: second start driven during the done cycle
    do_op(8'd255, 8'd16, 1'b0, lat, bb);
    chk("b2b1_q", q_u, 8'd15);
    chk("b2b1_r", r_u, 8'd15);
    do_op(8'd17, 8'd5, 1'b0, lat, bb);
    chk("b2b2_lat", lat, 9);
    chk("b2b2_busy", bb, 0);
    chk("b2b2_q", q_u, 8'd3);
    chk("b2b2_r", r_u, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
